// File: rtl/fp4_pkg.sv
// FP4 (E2M1) shared definitions.
// Field widths, special codes, rounding thresholds and packer states.
package fp4_pkg;

  localparam int FP4_W   = 4;
  localparam int FP4_E_W = 2;
  localparam int FP4_M_W = 1;

  localparam logic [FP4_W-1:0] FP4_ZERO    = 4'b0000;
  localparam logic [2:0]       FP4_MAX_MAG = 3'b111;

  // Grid midpoints and max, in units of 0.25
  localparam int Q_T0  = 1;   // 0.25
  localparam int Q_T1  = 3;   // 0.75
  localparam int Q_T2  = 5;   // 1.25
  localparam int Q_T3  = 7;   // 1.75
  localparam int Q_T4  = 10;  // 2.5
  localparam int Q_T5  = 14;  // 3.5
  localparam int Q_T6  = 20;  // 5.0
  localparam int Q_MAX = 24;  // 6.0

  typedef enum logic {
    PK_EMPTY,
    PK_HALF
  } pk_state_t;

  // Quarter-unit constant scaled to a 4x magnitude with frac bits
  function automatic int fp4_thr(int q, int frac);
    return q << frac;
  endfunction

endpackage

// File: rtl/fp4_encode.sv
// Fixed-point to E2M1 encoder.
// Round to nearest, ties to even mantissa, saturating at 6.0.
module fp4_encode
  import fp4_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int FRAC = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [FP4_W-1:0] code,
  output logic             sat
);

  localparam int MW = IN_W + 3;

  localparam logic [MW-1:0] T0 = MW'(fp4_thr(Q_T0, FRAC));
  localparam logic [MW-1:0] T1 = MW'(fp4_thr(Q_T1, FRAC));
  localparam logic [MW-1:0] T2 = MW'(fp4_thr(Q_T2, FRAC));
  localparam logic [MW-1:0] T3 = MW'(fp4_thr(Q_T3, FRAC));
  localparam logic [MW-1:0] T4 = MW'(fp4_thr(Q_T4, FRAC));
  localparam logic [MW-1:0] T5 = MW'(fp4_thr(Q_T5, FRAC));
  localparam logic [MW-1:0] T6 = MW'(fp4_thr(Q_T6, FRAC));
  localparam logic [MW-1:0] TM = MW'(fp4_thr(Q_MAX, FRAC));

  logic            neg;
  logic [IN_W:0]   xe;
  logic [IN_W:0]   mag;
  logic [MW-1:0]   mag4;
  logic [2:0]      mc;

  // Magnitude in 4x units so all midpoints are integers; <= ties
  // round down to even m, < ties round up to even m.
  always_comb begin
    neg  = din[IN_W-1];
    xe   = {din[IN_W-1], din};
    mag  = neg ? (~xe + 1'b1) : xe;
    mag4 = {mag, 2'b00};
    sat  = mag4 > TM;
    if (mag4 <= T0)      mc = 3'b000;
    else if (mag4 < T1)  mc = 3'b001;
    else if (mag4 <= T2) mc = 3'b010;
    else if (mag4 < T3)  mc = 3'b011;
    else if (mag4 <= T4) mc = 3'b100;
    else if (mag4 < T5)  mc = 3'b101;
    else if (mag4 <= T6) mc = 3'b110;
    else                 mc = FP4_MAX_MAG;
    code = (mc == 3'b000) ? FP4_ZERO : {neg, mc};
  end

endmodule

// File: rtl/fp4_quant_packer.sv
// Streaming fixed-point to FP4 quantizer.
// Packs two codes per byte, counts saturated samples.
module fp4_quant_packer
  import fp4_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int FRAC  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] sat_count,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pk_state_t        state;
  pk_state_t        state_nxt;
  logic [FP4_W-1:0] code;
  logic             sat;
  logic [FP4_W-1:0] held;
  logic             acc;
  logic             load;
  logic             hold;
  logic [7:0]       byte_nxt;

  assign s_ready = !m_valid || m_ready;
  assign acc     = s_valid && s_ready;

  fp4_encode #(
    .IN_W(IN_W),
    .FRAC(FRAC)
  ) u_enc (
    .din (s_data),
    .code(code),
    .sat (sat)
  );

  // Packer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PK_EMPTY;
    else        state <= state_nxt;
  end

  // Packer next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      PK_EMPTY: if (acc && !s_last) state_nxt = PK_HALF;
      PK_HALF:  if (acc)            state_nxt = PK_EMPTY;
      default:                      state_nxt = PK_EMPTY;
    endcase
  end

  // Packer actions: hold low nibble or emit a byte
  always_comb begin
    load     = 1'b0;
    hold     = 1'b0;
    byte_nxt = {FP4_ZERO, code};
    unique case (state)
      PK_EMPTY: begin
        load = acc && s_last;
        hold = acc && !s_last;
      end
      PK_HALF: begin
        load     = acc;
        byte_nxt = {code, held};
      end
      default: ;
    endcase
  end

  // Held low nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    held <= FP4_ZERO;
    else if (hold) held <= code;
  end

  // Output register; holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= 8'h00;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= byte_nxt;
      m_last  <= s_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Saturation event counter; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (cnt_clr)
      sat_count <= '0;
    else if (acc && sat && sat_count != CNT_MAX)
      sat_count <= sat_count + 1'b1;
  end

endmodule

// File: tb/tb_fp4_quant_packer.sv
// Testbench for fp4_quant_packer.
// Scoreboard of expected bytes vs bytes seen at the output.
module tb_fp4_quant_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [15:0] sat_count;
  logic        cnt_clr = 1'b0;

  logic [15:0] sw_x = '0;
  logic [3:0]  sw_code;
  logic        sw_sat;

  int checks = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  logic       mdl_half;
  logic [3:0] mdl_held;

  always #5 clk = ~clk;

  fp4_quant_packer #(
    .IN_W (16),
    .FRAC (8),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_last   (s_last),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .sat_count(sat_count),
    .cnt_clr  (cnt_clr)
  );

  fp4_encode #(
    .IN_W(16),
    .FRAC(8)
  ) u_sweep (
    .din (sw_x),
    .code(sw_code),
    .sat (sw_sat)
  );

  always @(negedge clk)
    if (rst_n && m_valid && m_ready)
      got_q.push_back({m_last, m_data});

  // Reference: nearest grid point by distance, ties to even index
  function automatic logic [4:0] ref_enc(input logic [15:0] x);
    real g[8];
    real v, a, d, bd;
    int  best;
    g = '{0.0, 0.5, 1.0, 1.5, 2.0, 3.0, 4.0, 6.0};
    v = $itor($signed(x)) / 256.0;
    a = (v < 0.0) ? -v : v;
    best = 0;
    for (int i = 1; i < 8; i++) begin
      d  = (a > g[i]) ? a - g[i] : g[i] - a;
      bd = (a > g[best]) ? a - g[best] : g[best] - a;
      if (d < bd || (d == bd && (i % 2) == 0)) best = i;
    end
    if (best == 0) return {1'b0, 4'b0000};
    return {a > 6.0, v < 0.0, 3'(best)};
  endfunction

  task automatic model(input logic [15:0] d, input logic l);
    logic [4:0] e;
    e = ref_enc(d);
    if (mdl_half) begin
      exp_q.push_back({l, e[3:0], mdl_held});
      mdl_half = 1'b0;
    end else if (l) begin
      exp_q.push_back({1'b1, 4'b0000, e[3:0]});
    end else begin
      mdl_held = e[3:0];
      mdl_half = 1'b1;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL send_timeout s_ready=%b required=1", s_ready);
    end
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_bytes(output bit to);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    to = (n >= 200);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({m_valid, m_last, m_data} !== 10'h0) begin
      failures++;
      $display("FAIL rst_out got=%h required=000", {m_valid, m_last, m_data});
    end
    checks++;
    if (sat_count !== 16'h0) begin
      failures++;
      $display("FAIL rst_cnt got=%h required=0000", sat_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b required=1", s_ready);
    end
  endtask

  task automatic test_basic();
    bit to;
    logic [8:0] g, e;
    exp_q.push_back(9'h032);
    send(16'h0100, 1'b0);
    send(16'h0180, 1'b0);
    exp_q.push_back(9'h10A);
    send(16'hFF00, 1'b1);
    wait_bytes(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL basic_byte got=%h required=%h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_rounding();
    bit to;
    logic [8:0] g, e;
    exp_q.push_back(9'h042);
    send(16'h00C0, 1'b0);
    send(16'h0280, 1'b0);
    exp_q.push_back(9'h060);
    send(16'h0040, 1'b0);
    send(16'h0380, 1'b0);
    exp_q.push_back(9'h076);
    send(16'h0500, 1'b0);
    send(16'h0501, 1'b0);
    exp_q.push_back(9'h100);
    send(16'hFFD0, 1'b1);
    wait_bytes(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL round_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL round_byte got=%h required=%h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_saturation();
    bit to;
    logic [8:0] g, e;
    exp_q.push_back(9'h0F7);
    send(16'h6400, 1'b0);
    send(16'h8000, 1'b0);
    exp_q.push_back(9'h0F7);
    send(16'h0600, 1'b0);
    send(16'hFA00, 1'b0);
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd2) begin
      failures++;
      $display("FAIL sat_count2 got=%0d required=2", sat_count);
    end
    cnt_clr = 1'b1;
    exp_q.push_back(9'h107);
    send(16'h7FFF, 1'b1);
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd0) begin
      failures++;
      $display("FAIL sat_clr got=%0d required=0", sat_count);
    end
    exp_q.push_back(9'h107);
    send(16'h0601, 1'b1);
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd1) begin
      failures++;
      $display("FAIL sat_count1 got=%0d required=1", sat_count);
    end
    wait_bytes(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL sat_count_bytes got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL sat_byte got=%h required=%h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    bit to;
    bit stalled;
    logic [8:0]  g, e;
    logic [15:0] vals[8];
    vals = '{16'h0100, 16'h0280, 16'hFE80, 16'h0333,
             16'h7000, 16'h0080, 16'hFF40, 16'h0200};
    mdl_half = 1'b0;
    stalled  = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          model(vals[i], i == 7);
          send(vals[i], i == 7);
        end
      end
      begin
        logic       pv;
        logic [8:0] pd;
        pv = 1'b0;
        pd = '0;
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (s_ready !== !m_valid) begin
            failures++;
            $display("FAIL bp_ready got=%b required=%b", s_ready, !m_valid);
          end
          if (!s_ready) stalled = 1'b1;
          if (m_valid && pv) begin
            checks++;
            if ({m_last, m_data} !== pd) begin
              failures++;
              $display("FAIL bp_hold got=%h required=%h", {m_last, m_data}, pd);
            end
          end
          pv = m_valid;
          pd = {m_last, m_data};
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    checks++;
    if (!stalled) begin
      failures++;
      $display("FAIL bp_stall got=0 required=1");
    end
    wait_bytes(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL bp_byte got=%h required=%h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_midframe();
    bit to;
    logic [8:0] g, e;
    send(16'h6400, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({m_valid, m_last, m_data, sat_count} !== 26'h0) begin
      failures++;
      $display("FAIL midrst_out got=%h required=0",
               {m_valid, m_last, m_data, sat_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(9'h022);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    wait_bytes(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midrst_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL midrst_byte got=%h required=%h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_sweep();
    logic [4:0] e;
    int nbad;
    nbad = 0;
    for (int i = 0; i < 65536; i++) begin
      sw_x = i[15:0];
      #1;
      e = ref_enc(sw_x);
      checks++;
      if ({sw_sat, sw_code} !== e) begin
        failures++;
        nbad++;
        if (nbad <= 10)
          $display("FAIL sweep x=%h got=%h required=%h", sw_x, {sw_sat, sw_code}, e);
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
